// File: rtl/life_rule_cell.sv
// Single-cell Game-of-Life rule evaluator.
// Combinational next state and neighbour count, a one-cycle registered copy,
// and saturating birth/death statistics for the current generation.
module life_rule_cell #(
  parameter logic [8:0] BIRTH_MASK   = 9'b0_0000_1000,
  parameter logic [8:0] SURVIVE_MASK = 9'b0_0000_1100,
  parameter int         CNT_WIDTH    = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8:0]           status,
  input  logic                 in_valid,
  input  logic                 stat_clr,
  output logic                 live,
  output logic [3:0]           neighbor_cnt,
  output logic                 live_q,
  output logic [3:0]           cnt_q,
  output logic                 out_valid,
  output logic [CNT_WIDTH-1:0] birth_cnt,
  output logic [CNT_WIDTH-1:0] death_cnt
);

  localparam int STAGES = 1;

  // Masks widened to the full 4-bit index range so an index above 8 can
  // never select an undefined bit.
  localparam logic [15:0] BIRTH_EXT   = {7'b0, BIRTH_MASK};
  localparam logic [15:0] SURVIVE_EXT = {7'b0, SURVIVE_MASK};

  logic [STAGES:0] vld_pipe;
  logic            centre;
  logic            is_birth;
  logic            is_death;

  assign centre = status[0];

  // Popcount of the eight neighbours; the centre bit is never counted.
  always_comb begin
    neighbor_cnt = 4'd0;
    for (int i = 1; i < 9; i++) begin
      neighbor_cnt = neighbor_cnt + {3'b000, status[i]};
    end
  end

  // Rule lookup: survive table for a live centre, birth table for a dead one.
  always_comb begin
    live = centre ? SURVIVE_EXT[neighbor_cnt] : BIRTH_EXT[neighbor_cnt];
  end

  assign is_birth = in_valid & ~centre &  live;
  assign is_death = in_valid &  centre & ~live;

  // Valid shift register: stage 0 is the live input, top stage is out_valid.
  assign vld_pipe[0] = in_valid;
  assign out_valid   = vld_pipe[STAGES];

  // Valid pipeline; a reset drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe[STAGES:1] <= '0;
    else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  // Result register, loaded only on accepted evaluations and held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q <= 1'b0;
      cnt_q  <= 4'd0;
    end else if (in_valid) begin
      live_q <= live;
      cnt_q  <= neighbor_cnt;
    end
  end

  // Birth counter: clear has priority, then saturating increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               birth_cnt <= '0;
    else if (stat_clr)                     birth_cnt <= '0;
    else if (is_birth && birth_cnt != '1)  birth_cnt <= birth_cnt + 1'b1;
  end

  // Death counter: clear has priority, then saturating increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               death_cnt <= '0;
    else if (stat_clr)                     death_cnt <= '0;
    else if (is_death && death_cnt != '1)  death_cnt <= death_cnt + 1'b1;
  end

endmodule

// File: tb/tb_life_rule_cell.sv
// Directed bench for life_rule_cell: default B3/S23 instance, a 2-bit
// counter instance for saturation, and a HighLife (B36/S23) instance.
module tb_life_rule_cell;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] status;
  logic       in_valid;
  logic       stat_clr;

  logic        live, live_q, out_valid;
  logic [3:0]  neighbor_cnt, cnt_q;
  logic [23:0] birth_cnt, death_cnt;

  logic        s_live, s_live_q, s_out_valid;
  logic [3:0]  s_ncnt, s_cnt_q;
  logic [1:0]  s_birth, s_death;

  logic        h_live, h_live_q, h_out_valid;
  logic [3:0]  h_ncnt, h_cnt_q;
  logic [23:0] h_birth, h_death;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  life_rule_cell u_dut (
    .clk(clk), .rst(rst), .status(status), .in_valid(in_valid), .stat_clr(stat_clr),
    .live(live), .neighbor_cnt(neighbor_cnt), .live_q(live_q), .cnt_q(cnt_q),
    .out_valid(out_valid), .birth_cnt(birth_cnt), .death_cnt(death_cnt)
  );

  life_rule_cell #(.CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .status(status), .in_valid(in_valid), .stat_clr(stat_clr),
    .live(s_live), .neighbor_cnt(s_ncnt), .live_q(s_live_q), .cnt_q(s_cnt_q),
    .out_valid(s_out_valid), .birth_cnt(s_birth), .death_cnt(s_death)
  );

  life_rule_cell #(.BIRTH_MASK(9'h048), .SURVIVE_MASK(9'h00C)) u_hl (
    .clk(clk), .rst(rst), .status(status), .in_valid(in_valid), .stat_clr(stat_clr),
    .live(h_live), .neighbor_cnt(h_ncnt), .live_q(h_live_q), .cnt_q(h_cnt_q),
    .out_valid(h_out_valid), .birth_cnt(h_birth), .death_cnt(h_death)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int n;
    logic [8:0] s;
    logic e_live, e_hl;

    rst = 1'b1; status = 9'h000; in_valid = 1'b0; stat_clr = 1'b0;
    #2;
    chk("rst_live_q",    32'(live_q),    0);
    chk("rst_cnt_q",     32'(cnt_q),     0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_birth",     32'(birth_cnt), 0);
    chk("rst_death",     32'(death_cnt), 0);
    status = 9'h00E; #1;
    chk("rst_live_comb", 32'(live), 1);

    @(negedge clk); rst = 1'b0; status = 9'h000;
    @(negedge clk);

    // Exhaustive combinational sweep against hand rules.
    for (int v = 0; v < 512; v++) begin
      s = 9'(v);
      status = s; #1;
      n = $countones(s[8:1]);
      e_live = s[0] ? (n == 2 || n == 3) : (n == 3);
      e_hl   = s[0] ? (n == 2 || n == 3) : (n == 3 || n == 6);
      chk($sformatf("sweep_live_%03h", s), 32'(live), 32'(e_live));
      chk($sformatf("sweep_cnt_%03h", s),  32'(neighbor_cnt), 32'(n));
      chk($sformatf("sweep_hl_%03h", s),   32'(h_live), 32'(e_hl));
    end
    status = 9'h00E; #1; chk("vec_00E", 32'(live), 1);
    status = 9'h007; #1; chk("vec_007", 32'(live), 1);
    status = 9'h1FF; #1; chk("vec_1FF", 32'(live), 0);
    status = 9'h001; #1; chk("vec_001", 32'(live), 0);

    // Registered path, single accept then idle.
    @(negedge clk); status = 9'h00E; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0; status = 9'h000;
    chk("reg_out_valid", 32'(out_valid), 1);
    chk("reg_live_q",    32'(live_q),    1);
    chk("reg_cnt_q",     32'(cnt_q),     3);
    chk("reg_birth",     32'(birth_cnt), 1);
    @(negedge clk);
    chk("idle_out_valid", 32'(out_valid), 0);
    chk("idle_live_q",    32'(live_q),    1);
    chk("idle_cnt_q",     32'(cnt_q),     3);

    // Back-to-back death then survival.
    @(negedge clk); status = 9'h003; in_valid = 1'b1;
    @(negedge clk); status = 9'h00F;
    chk("b2b1_out_valid", 32'(out_valid), 1);
    chk("b2b1_live_q",    32'(live_q),    0);
    chk("b2b1_cnt_q",     32'(cnt_q),     1);
    @(negedge clk); in_valid = 1'b0;
    chk("b2b2_out_valid", 32'(out_valid), 1);
    chk("b2b2_live_q",    32'(live_q),    1);
    chk("b2b2_cnt_q",     32'(cnt_q),     3);
    chk("stat_birth",     32'(birth_cnt), 1);
    chk("stat_death",     32'(death_cnt), 1);

    // Clear wins over a simultaneous birth.
    @(negedge clk); status = 9'h00E; in_valid = 1'b1; stat_clr = 1'b1;
    @(negedge clk); in_valid = 1'b0; stat_clr = 1'b0;
    chk("clr_birth",     32'(birth_cnt), 0);
    chk("clr_death",     32'(death_cnt), 0);
    chk("clr_sat_birth", 32'(s_birth),   0);
    chk("clr_out_valid", 32'(out_valid), 1);

    // Five births: 2-bit counter saturates at 3.
    @(negedge clk); status = 9'h00E; in_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("sat_birth",  32'(s_birth),   3);
    chk("sat_death",  32'(s_death),   0);
    chk("full_birth", 32'(birth_cnt), 5);

    // HighLife vs default on a dead centre with six neighbours.
    status = 9'h07E; #1;
    chk("hl_b6_live",  32'(h_live), 1);
    chk("def_b6_live", 32'(live),   0);
    status = 9'h00E;

    // Async reset between edges while results are held.
    @(negedge clk); #2; rst = 1'b1; #1;
    chk("arst_live_q",    32'(live_q),    0);
    chk("arst_cnt_q",     32'(cnt_q),     0);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_birth",     32'(birth_cnt), 0);
    chk("arst_death",     32'(death_cnt), 0);
    chk("arst_sat_birth", 32'(s_birth),   0);
    status = 9'h007; #1;
    chk("arst_live_007", 32'(live), 1);
    status = 9'h1FF; #1;
    chk("arst_live_1FF", 32'(live), 0);
    chk("arst_cnt_1FF",  32'(neighbor_cnt), 8);

    // Release with no valid: nothing emerges until a fresh accept.
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_out_valid", 32'(out_valid), 0);
    status = 9'h007; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    chk("post2_out_valid", 32'(out_valid), 1);
    chk("post2_live_q",    32'(live_q),    1);
    chk("post2_cnt_q",     32'(cnt_q),     2);
    chk("post2_birth",     32'(birth_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_rule_cell.md
Name: life_rule_cell

Overview:
- Evaluates the Game-of-Life transition for one cell from its 3x3 neighbourhood.
- Sits beside the global evolution sequencer (Round). The sequencer gathers the nine cell states and samples `live` when it asserts its write enable.
- Provides a zero-latency combinational result and a registered copy.
- Keeps saturating birth/death statistics for the current generation.

Parameters:
- BIRTH_MASK, default 9'b0_0000_1000: bit k=1 means a dead cell with k live neighbours becomes alive (default B3).
- SURVIVE_MASK, default 9'b0_0000_1100: bit k=1 means a live cell with k live neighbours stays alive (default S23).
- CNT_WIDTH, default 24: width of the birth/death statistic counters.

Ports:
- clk  input  1  system clock; all sequential logic on its rising edge
- rst  input  1  asynchronous, active-high reset
- status  input  9  neighbourhood states:
  - bit0 = centre (i,j).
  - bits1..8 = the eight neighbours, clockwise starting at (i,j+1). Bit order among 1..8 is irrelevant to the result.
- in_valid  input  1  status is a complete neighbourhood to be registered and counted this cycle
- stat_clr  input  1  synchronous clear of the statistic counters
- live  output  1  combinational next state of the centre cell
- neighbor_cnt  output  4  combinational count of live neighbours, 0..8
- live_q  output  1  registered live
- cnt_q  output  4  registered neighbor_cnt
- out_valid  output  1  live_q/cnt_q updated in the previous cycle
- birth_cnt  output  CNT_WIDTH  number of accepted evaluations where a dead centre became alive
- death_cnt  output  CNT_WIDTH  number of accepted evaluations where a live centre died

Behaviour:
- neighbor_cnt = popcount(status[8:1]), 4-bit unsigned, range 0..8. status[0] is never counted.
- live = status[0] ? SURVIVE_MASK[neighbor_cnt] : BIRTH_MASK[neighbor_cnt].
  - Purely combinational: valid in the same cycle status changes.
  - Unaffected by clk, rst, in_valid.
  - No X-propagation on a 9-bit mask index (count never exceeds 8).
- With default masks:
  - Live centre: live=1 only for count 2 or 3.
  - Dead centre: live=1 only for count 3.
  - All other combinations give 0.
- Registered path, each rising edge:
  - in_valid=1: live_q <= live, cnt_q <= neighbor_cnt, out_valid <= 1.
  - in_valid=0: out_valid <= 0; live_q and cnt_q hold their values.
  - Latency is one cycle from in_valid to out_valid.
  - There is no back-pressure; every valid cycle is accepted.
- Statistics, each rising edge:
  - stat_clr=1: birth_cnt <= 0, death_cnt <= 0. Clear wins over a simultaneous in_valid increment; that evaluation is not counted.
  - Else if in_valid=1 and status[0]=0 and live=1: birth_cnt += 1.
  - Else if in_valid=1 and status[0]=1 and live=0: death_cnt += 1.
  - Survival and dead-stays-dead change neither counter.
  - Both counters saturate at all-ones (2^CNT_WIDTH-1); they never wrap.
- Reset, asynchronous: while rst=1, live_q=0, cnt_q=0, out_valid=0, birth_cnt=0, death_cnt=0.
  - Reset mid-stream discards any pending result; the first result after release needs a fresh in_valid.
  - live and neighbor_cnt stay combinational during reset.
- Back-to-back in_valid cycles produce back-to-back out_valid cycles, each carrying its own result.

Test Plan:
- Exhaustive sweep of status 0..511, in_valid=0 → live matches B3/S23 for every value, e.g.:
  - 9'h00E (dead centre, 3 neighbours) → 1.
  - 9'h007 (live centre, 2 neighbours) → 1.
  - 9'h1FF (8 neighbours) → 0.
  - 9'h001 (lone live centre) → 0.
  - neighbor_cnt equals the popcount of bits 8..1 in every case.
- Registered path: status=9'h00E with in_valid=1 for one cycle → next cycle out_valid=1, live_q=1, cnt_q=3. The following idle cycle gives out_valid=0 with live_q still 1.
- Statistics: accept 9'h00E (birth), 9'h003 (live centre, 1 neighbour, death), then 9'h00F (survival) → birth_cnt=1, death_cnt=1. Assert stat_clr together with a birth input → both counters 0.
- Saturation with CNT_WIDTH=2: accept five births → birth_cnt stays 3.
- Async reset: assert rst between clock edges after results are held → live_q, cnt_q, out_valid and both counters read 0 immediately. live still tracks status during reset.
- Custom masks BIRTH_MASK=9'h048, SURVIVE_MASK=9'h00C (HighLife) → dead centre with 6 neighbours gives live=1; with the default masks it gives 0.
